// File: rtl/nf_responder.sv
// nf_responder: device-side model of a parallel NOR flash (StrataFlash-style command
// subset) for on-chip or simulated loopback against the flash controller.
//
// Holds a 256-byte array. Supports read array, read/clear status, byte program
// (bits only clear) and full-array erase. Busy time is modelled on NF_STS and SR7.
//
// Ports:
//   CLK_50MHZ  clock, rising edge
//   RST        synchronous active-high reset (starts the power-up erase sweep)
//   NF_A       byte address
//   NF_D_IN    write data from the controller
//   NF_D_OUT   read data (array or status), 0x00 when not driving
//   NF_D_OE    drive enable for the shared data bus
//   NF_CE/NF_OE/NF_WE  active-low chip enable, output enable, write enable
//   NF_RP      active-low reset/power-down (aborts any operation)
//   NF_WP      active-low write protect
//   NF_BYTE    unused; byte mode only
//   NF_STS     1 = ready, 0 = busy (registered)
module nf_responder #(
  parameter int unsigned PROG_CYCLES  = 16,
  parameter int unsigned ERASE_CYCLES = 64
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic [7:0] NF_A,
  input  logic [7:0] NF_D_IN,
  output logic [7:0] NF_D_OUT,
  output logic       NF_D_OE,
  input  logic       NF_CE,
  input  logic       NF_OE,
  input  logic       NF_WE,
  input  logic       NF_RP,
  input  logic       NF_WP,
  input  logic       NF_BYTE,
  output logic       NF_STS
);

  localparam logic [2:0] StInit       = 3'd0;
  localparam logic [2:0] StRdArray    = 3'd1;
  localparam logic [2:0] StRdStatus   = 3'd2;
  localparam logic [2:0] StProgSetup  = 3'd3;
  localparam logic [2:0] StEraseSetup = 3'd4;
  localparam logic [2:0] StProgBusy   = 3'd5;
  localparam logic [2:0] StEraseWait  = 3'd6;
  localparam logic [2:0] StEraseSweep = 3'd7;

  // Busy counter terminal values: PROG_BUSY spans counts 0..PROG_CYCLES (the last
  // count is the array update), ERASE_WAIT spans counts 0..ERASE_CYCLES-1.
  localparam logic [15:0] ProgLast  = 16'(PROG_CYCLES);
  localparam logic [15:0] EraseLast = 16'(ERASE_CYCLES - 1);

  logic [7:0]  mem [256];

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  sweep_q, sweep_d;
  logic        we_q;
  logic [7:0]  a_q, d_q;
  logic [7:0]  prog_addr_q, prog_addr_d;
  logic [7:0]  prog_data_q, prog_data_d;
  logic        sr5_q, sr5_d;
  logic        sr4_q, sr4_d;
  logic        sr1_q, sr1_d;
  logic        sts_q;

  logic        wr_ev;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic [7:0]  sr;
  logic        unused_byte;

  assign unused_byte = NF_BYTE;

  function automatic logic is_busy(input logic [2:0] st);
    return (st == StInit) || (st == StProgBusy) || (st == StEraseWait) ||
           (st == StEraseSweep);
  endfunction

  // Rising edge of WE while the chip is selected; address/data come from the low phase.
  assign wr_ev = !we_q && NF_WE && !NF_CE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sweep_d     = sweep_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    sr5_d       = sr5_q;
    sr4_d       = sr4_q;
    sr1_d       = sr1_q;
    mem_we      = 1'b0;
    mem_waddr   = sweep_q;
    mem_wdata   = 8'hFF;

    if (!NF_RP) begin
      state_d = StRdArray;
      cnt_d   = '0;
      sweep_d = '0;
      sr5_d   = 1'b0;
      sr4_d   = 1'b0;
      sr1_d   = 1'b0;
    end else begin
      case (state_q)
        StInit, StEraseSweep: begin
          mem_we  = 1'b1;
          sweep_d = sweep_q + 8'd1;
          // Counter wraps to 0 after address 255, which ends the sweep.
          if (sweep_q == 8'hFF) begin
            state_d = (state_q == StInit) ? StRdArray : StRdStatus;
          end
        end
        StRdArray, StRdStatus: begin
          if (wr_ev) begin
            case (d_q)
              8'hFF: state_d = StRdArray;
              8'h70: state_d = StRdStatus;
              8'h50: begin
                sr5_d = 1'b0;
                sr4_d = 1'b0;
                sr1_d = 1'b0;
              end
              8'h40, 8'h10: state_d = StProgSetup;
              8'h20: state_d = StEraseSetup;
              default: ;
            endcase
          end
        end
        StProgSetup: begin
          if (wr_ev) begin
            prog_addr_d = a_q;
            prog_data_d = d_q;
            if (!NF_WP) begin
              sr4_d   = 1'b1;
              sr1_d   = 1'b1;
              state_d = StRdStatus;
            end else begin
              cnt_d   = '0;
              state_d = StProgBusy;
            end
          end
        end
        StEraseSetup: begin
          if (wr_ev) begin
            if (d_q == 8'hD0) begin
              if (NF_WP) begin
                cnt_d   = '0;
                state_d = StEraseWait;
              end else begin
                sr5_d   = 1'b1;
                sr1_d   = 1'b1;
                state_d = StRdStatus;
              end
            end else begin
              sr5_d   = 1'b1;
              sr4_d   = 1'b1;
              state_d = StRdStatus;
            end
          end
        end
        StProgBusy: begin
          if (cnt_q == ProgLast) begin
            mem_we    = 1'b1;
            mem_waddr = prog_addr_q;
            mem_wdata = mem[prog_addr_q] & prog_data_q;
            cnt_d     = '0;
            state_d   = StRdStatus;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StEraseWait: begin
          if (cnt_q == EraseLast) begin
            cnt_d   = '0;
            sweep_d = '0;
            state_d = StEraseSweep;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      sweep_q     <= '0;
      we_q        <= 1'b1;
      a_q         <= '0;
      d_q         <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      sr5_q       <= 1'b0;
      sr4_q       <= 1'b0;
      sr1_q       <= 1'b0;
      sts_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sweep_q     <= sweep_d;
      we_q        <= NF_WE;
      if (!NF_WE) begin
        a_q <= NF_A;
        d_q <= NF_D_IN;
      end
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      sr5_q       <= sr5_d;
      sr4_q       <= sr4_d;
      sr1_q       <= sr1_d;
      // Registered so STS falls on the same edge that enters a busy state.
      sts_q       <= !is_busy(state_d);
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign sr      = {!is_busy(state_q), 1'b0, sr5_q, sr4_q, 2'b00, sr1_q, 1'b0};
  assign NF_D_OE = !NF_CE && !NF_OE && NF_WE && NF_RP;

  always_comb begin
    NF_D_OUT = 8'h00;
    if (NF_D_OE) begin
      NF_D_OUT = (state_q == StRdArray) ? mem[NF_A] : sr;
    end
  end

  assign NF_STS = sts_q;

endmodule

// File: tb/tb_nf_responder.sv
// Directed bench for nf_responder: reset sweep, program, erase, status errors,
// NF_RP abort and busy-state write isolation with default timing parameters.
module tb_nf_responder;

  logic       clk;
  logic       rst;
  logic [7:0] nf_a;
  logic [7:0] nf_d_in;
  logic [7:0] nf_d_out;
  logic       nf_d_oe;
  logic       nf_ce;
  logic       nf_oe;
  logic       nf_we;
  logic       nf_rp;
  logic       nf_wp;
  logic       nf_byte;
  logic       nf_sts;

  int vectors;
  int miscompares;
  int n;

  nf_responder dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .NF_A      (nf_a),
    .NF_D_IN   (nf_d_in),
    .NF_D_OUT  (nf_d_out),
    .NF_D_OE   (nf_d_oe),
    .NF_CE     (nf_ce),
    .NF_OE     (nf_oe),
    .NF_WE     (nf_we),
    .NF_RP     (nf_rp),
    .NF_WP     (nf_wp),
    .NF_BYTE   (nf_byte),
    .NF_STS    (nf_sts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus write: WE low for a cycle, then high with CE still low (edge detected).
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    nf_ce   = 1'b0;
    nf_we   = 1'b0;
    nf_a    = a;
    nf_d_in = d;
    @(negedge clk);
    nf_we = 1'b1;
    @(negedge clk);
    nf_ce = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    nf_ce = 1'b0;
    nf_oe = 1'b0;
    nf_a  = a;
    #1;
    check({tag, "_oe"}, 32'(nf_d_oe), 32'd1);
    check(tag, 32'(nf_d_out), 32'(exp));
    nf_oe = 1'b1;
    nf_ce = 1'b1;
  endtask

  // Number of consecutive negedges (starting now) with NF_STS low; bounded.
  task automatic count_low(output int cnt);
    cnt = 0;
    while (nf_sts === 1'b0 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    nf_a    = 8'h00;
    nf_d_in = 8'h00;
    nf_ce   = 1'b1;
    nf_oe   = 1'b1;
    nf_we   = 1'b1;
    nf_rp   = 1'b1;
    nf_wp   = 1'b1;
    nf_byte = 1'b0;

    // Reset for two cycles, then the 256-cycle power-up sweep.
    @(negedge clk);
    @(negedge clk);
    check("rst_sts", 32'(nf_sts), 32'd0);
    check("rst_doe", 32'(nf_d_oe), 32'd0);
    check("rst_dout", 32'(nf_d_out), 32'h00);
    rst = 1'b0;
    count_low(n);
    check("init_busy_cycles", 32'(n), 32'd256);
    rd("init_read_37", 8'h37, 8'hFF);

    // Program 0xA5 to 0x12.
    wr(8'h00, 8'h40);
    check("setup_sts", 32'(nf_sts), 32'd1);
    wr(8'h12, 8'hA5);
    count_low(n);
    check("prog_busy_cycles", 32'(n), 32'd17);
    rd("prog_sr", 8'h12, 8'h80);
    wr(8'h00, 8'hFF);
    rd("prog_read_12", 8'h12, 8'hA5);

    // Program 0x0F on top: bits only clear -> 0x05.
    wr(8'h00, 8'h40);
    wr(8'h12, 8'h0F);
    rd("prog_busy_sr", 8'h12, 8'h00);
    count_low(n);
    check("prog2_busy_cycles", 32'(n), 32'd17);
    wr(8'h00, 8'hFF);
    rd("prog2_read_12", 8'h12, 8'h05);

    // Alternate program opcode 0x10.
    wr(8'h00, 8'h10);
    wr(8'h55, 8'hF0);
    count_low(n);
    check("prog10_busy_cycles", 32'(n), 32'd17);
    wr(8'h00, 8'hFF);
    rd("prog10_read_55", 8'h55, 8'hF0);

    // Full erase.
    wr(8'h00, 8'h20);
    wr(8'h00, 8'hD0);
    count_low(n);
    check("erase_busy_cycles", 32'(n), 32'd320);
    rd("erase_sr", 8'h12, 8'h80);
    wr(8'h00, 8'hFF);
    rd("erase_read_12", 8'h12, 8'hFF);
    rd("erase_read_55", 8'h55, 8'hFF);

    // Erase sequence error, then clear status.
    wr(8'h00, 8'h20);
    wr(8'h00, 8'h55);
    rd("seq_err_sr", 8'h00, 8'hB0);
    wr(8'h00, 8'h50);
    rd("clear_sr", 8'h00, 8'h80);

    // Program with write protect asserted.
    nf_wp = 1'b0;
    wr(8'h00, 8'h40);
    wr(8'h03, 8'h00);
    check("wp_sts", 32'(nf_sts), 32'd1);
    rd("wp_sr", 8'h03, 8'h92);
    nf_wp = 1'b1;
    wr(8'h00, 8'h50);
    wr(8'h00, 8'hFF);
    rd("wp_read_03", 8'h03, 8'hFF);

    // NF_RP abort in the middle of a program.
    wr(8'h00, 8'h40);
    wr(8'h40, 8'h3C);
    repeat (5) @(negedge clk);
    check("abort_pre_sts", 32'(nf_sts), 32'd0);
    nf_rp = 1'b0;
    nf_ce = 1'b0;
    nf_oe = 1'b0;
    nf_a  = 8'h40;
    #1;
    check("abort_doe", 32'(nf_d_oe), 32'd0);
    check("abort_dout", 32'(nf_d_out), 32'h00);
    nf_oe = 1'b1;
    nf_ce = 1'b1;
    @(negedge clk);
    nf_rp = 1'b1;
    check("abort_sts", 32'(nf_sts), 32'd1);
    rd("abort_read_40", 8'h40, 8'hFF);
    repeat (30) @(negedge clk);
    check("abort_late_sts", 32'(nf_sts), 32'd1);
    rd("abort_late_read_40", 8'h40, 8'hFF);

    // Writes during the erase sweep are ignored.
    wr(8'h00, 8'h20);
    wr(8'h00, 8'hD0);
    repeat (80) @(negedge clk);
    wr(8'h00, 8'hFF);
    rd("sweep_busy_sr", 8'h12, 8'h00);
    count_low(n);
    check("sweep_done_sts", 32'(nf_sts), 32'd1);
    rd("sweep_end_sr", 8'h12, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
